button_event: RTL and testbench

Classifies a debounced, active-high push-button level into single-cycle event pulses: press, release, long-press and auto-repeat while held. It sits directly downstream of the `debounce` stage, taking that stage's debounced output level as `in_signal`. Its pulses drive the front-panel control logic, for example manual single-step and run/halt. All timing decisions advance only on `in_clke` ticks, so hold times scale with the shared slow-tick enable.

---
 rtl/button_event_if.sv | 19 +
 rtl/button_event.sv | 82 ++++++++
 tb/tb_button_event.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// button_event_if: tick/enable/level inputs and registered event outputs of button_event.
interface button_event_if;
    logic in_clke;
    logic in_en;
    logic in_signal;
    logic out_press_reg;
    logic out_release_reg;
    logic out_long_reg;
    logic out_repeat_reg;
    logic out_held_reg;
    modport master (
        output in_clke, in_en, in_signal,
        input  out_press_reg, out_release_reg, out_long_reg, out_repeat_reg, out_held_reg
    );
    modport slave (
        input  in_clke, in_en, in_signal,
        output out_press_reg, out_release_reg, out_long_reg, out_repeat_reg, out_held_reg
    );
endinterface

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/long/repeat pulses,
// with all hold timing counted in in_clke ticks.
module button_event #(
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 2
) (
    input logic           in_clk,
    input logic           in_rst,
    button_event_if.slave bus
);
    localparam int CW = $clog2(LONG_TICKS);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          press_ev, release_ev, long_ev, repeat_ev;
    logic          tick;
    assign tick = bus.in_clke & bus.in_en;
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        press_ev   = 1'b0;
        release_ev = 1'b0;
        long_ev    = 1'b0;
        repeat_ev  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: if (bus.in_signal) begin
                    state_n  = HELD;
                    cnt_n    = '0;
                    press_ev = 1'b1;
                end
                HELD: if (!bus.in_signal) begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    release_ev = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_n = REPEAT;
                    cnt_n   = '0;
                    long_ev = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                REPEAT: if (!bus.in_signal) begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    release_ev = 1'b1;
                end else if (cnt == REP_LAST) begin
                    cnt_n     = '0;
                    repeat_ev = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                // unreachable encoding falls back to IDLE silently
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            bus.out_press_reg   <= 1'b0;
            bus.out_release_reg <= 1'b0;
            bus.out_long_reg    <= 1'b0;
            bus.out_repeat_reg  <= 1'b0;
            bus.out_held_reg    <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            bus.out_press_reg   <= press_ev;
            bus.out_release_reg <= release_ev;
            bus.out_long_reg    <= long_ev;
            bus.out_repeat_reg  <= repeat_ev;
            bus.out_held_reg    <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: randomized and directed checks of button_event against a
// hold-duration reference model.
module tb_button_event;
    localparam int L = 4;
    localparam int R = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_pressed = 1'b0;
    int   m_k = 0;
    logic [4:0] e_vec = '0;
    logic [4:0] obs;
    button_event_if bus ();
    button_event #(.LONG_TICKS(L), .REPEAT_TICKS(R)) dut (.in_clk(clk), .in_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign obs = {bus.out_press_reg, bus.out_release_reg, bus.out_long_reg, bus.out_repeat_reg, bus.out_held_reg};

    // model: ticks held since press decide long (k==L) and repeat (k>L, multiple of R past L)
    task automatic step(input bit c, input bit e, input bit s);
        @(negedge clk);
        bus.in_clke = c;
        bus.in_en = e;
        bus.in_signal = s;
        @(posedge clk);
        e_vec = '0;
        if (c && e) begin
            if (s && !m_pressed) begin
                m_pressed = 1'b1;
                m_k = 0;
                e_vec[4] = 1'b1;
            end else if (s) begin
                m_k++;
                if (m_k == L) e_vec[2] = 1'b1;
                else if (m_k > L && (m_k - L) % R == 0) e_vec[1] = 1'b1;
            end else if (m_pressed) begin
                m_pressed = 1'b0;
                e_vec[3] = 1'b1;
            end
        end
        e_vec[0] = m_pressed;
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1);
        step(1, 1, 1);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 5'b0) begin n_bad++; $display("FAIL reset_async: got %b want 00000", obs); end
        m_pressed = 1'b0;
        m_k = 0;
        bus.in_clke = 1'b0;
        @(negedge clk) rst = 1'b0;
        step(1, 1, 1);
        n_cmp++;
        if (obs !== 5'b10001) begin n_bad++; $display("FAIL reset_first_press: got %b want 10001", obs); end
        step(1, 1, 0);
        n_cmp++;
        if (obs !== e_vec) begin n_bad++; $display("FAIL reset_release: got %b want %b", obs, e_vec); end
    endtask

    task automatic test_short_press();
        int np = 0, nr = 0, nl = 0, held = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, i < 3);
            n_cmp++;
            if (obs !== e_vec) begin n_bad++; $display("FAIL short_press cycle %0d: got %b want %b", i, obs, e_vec); end
            np += obs[4]; nr += obs[3]; nl += obs[2] + obs[1]; held += obs[0];
        end
        n_cmp++;
        if ({np, nr, nl, held} !== {32'd1, 32'd1, 32'd0, 32'd3}) begin
            n_bad++; $display("FAIL short_press_counts: got press %0d rel %0d long/rep %0d held %0d want 1 1 0 3", np, nr, nl, held);
        end
    endtask

    task automatic test_long_hold();
        logic [15:0] pm = '0, lm = '0, rm = '0;
        for (int t = 0; t < 10; t++) begin
            step(1, 1, 1);
            n_cmp++;
            if (obs !== e_vec) begin n_bad++; $display("FAIL long_hold tick %0d: got %b want %b", t, obs, e_vec); end
            pm[t] = obs[4]; lm[t] = obs[2]; rm[t] = obs[1];
        end
        n_cmp++;
        if ({pm, lm, rm} !== {16'h0001, 16'h0010, 16'h0140}) begin
            n_bad++; $display("FAIL long_hold_ticks: got press %h long %h rep %h want 0001 0010 0140", pm, lm, rm);
        end
        step(1, 1, 0);
        n_cmp++;
        if (obs !== 5'b01000) begin n_bad++; $display("FAIL long_hold_release: got %b want 01000", obs); end
        step(1, 1, 0);
        n_cmp++;
        if (obs !== 5'b0) begin n_bad++; $display("FAIL long_hold_pulse_width: got %b want 00000", obs); end
    endtask

    task automatic test_slow_tick();
        int tp = -1, tl = -1, wide = 0;
        for (int i = 0; i < 18; i++) begin
            step(i % 3 == 0, 1, 1);
            n_cmp++;
            if (obs !== e_vec) begin n_bad++; $display("FAIL slow_tick cycle %0d: got %b want %b", i, obs, e_vec); end
            if (obs[4]) tp = i;
            if (obs[2]) tl = i;
            if (i % 3 != 0 && obs[4:1] != 4'b0) wide++;
        end
        n_cmp++;
        if (tl - tp !== 12 || tp !== 0 || wide !== 0) begin
            n_bad++; $display("FAIL slow_tick_timing: got press %0d long %0d wide %0d want 0 12 0", tp, tl, wide);
        end
        step(1, 1, 0);
        n_cmp++;
        if (obs !== e_vec) begin n_bad++; $display("FAIL slow_tick_release: got %b want %b", obs, e_vec); end
    endtask

    task automatic test_release_threshold();
        for (int t = 0; t < 4; t++) begin
            step(1, 1, 1);
            n_cmp++;
            if (obs !== e_vec) begin n_bad++; $display("FAIL thresh tick %0d: got %b want %b", t, obs, e_vec); end
        end
        step(1, 1, 0);
        n_cmp++;
        if (obs !== 5'b01000) begin n_bad++; $display("FAIL thresh_release: got %b want 01000", obs); end
        step(1, 1, 0);
        n_cmp++;
        if (obs !== 5'b0) begin n_bad++; $display("FAIL thresh_idle: got %b want 00000", obs); end
    endtask

    task automatic test_enable_freeze();
        int pulses = 0;
        for (int t = 0; t < 3; t++) step(1, 1, 1);
        n_cmp++;
        if (obs !== 5'b00001) begin n_bad++; $display("FAIL freeze_pre: got %b want 00001", obs); end
        for (int t = 0; t < 5; t++) begin
            step(1, 0, 1);
            pulses += obs[4] + obs[3] + obs[2] + obs[1];
        end
        n_cmp++;
        if (pulses !== 0 || obs !== 5'b00001) begin n_bad++; $display("FAIL freeze_hold: got %0d pulses out %b want 0 00001", pulses, obs); end
        step(1, 1, 1);
        n_cmp++;
        if (obs !== 5'b00001) begin n_bad++; $display("FAIL freeze_resume1: got %b want 00001", obs); end
        step(1, 1, 1);
        n_cmp++;
        if (obs !== 5'b00101) begin n_bad++; $display("FAIL freeze_resume2: got %b want 00101", obs); end
        step(1, 1, 0);
        step(1, 1, 0);
    endtask

    task automatic test_random();
        bit s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) s = ~s;
            step($urandom_range(2) != 0, $urandom_range(9) != 0, s);
            n_cmp++;
            if (obs !== e_vec) begin n_bad++; $display("FAIL random cycle %0d: got %b want %b", i, obs, e_vec); end
            n_cmp++;
            if (!$onehot0(obs[4:1])) begin n_bad++; $display("FAIL random_onehot cycle %0d: got %b want at most one pulse", i, obs); end
        end
        step(1, 1, 0);
        step(1, 1, 0);
    endtask

    initial begin
        bus.in_clke = 1'b0;
        bus.in_en = 1'b0;
        bus.in_signal = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_short_press();
        test_long_hold();
        test_slow_tick();
        test_release_threshold();
        test_enable_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
